// File: rtl/byte_lane_memory.sv
// rtl/byte_lane_memory.sv - byte/half/word/dword load-store controller over a one-cycle word RAM
// Define BYTE_LANE_MEMORY_BIG_ENDIAN_EN for big-endian lane order (legacy processor_memory layout).
module byte_lane_memory #(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 65536
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*DATA_BYTES-1:0] resp_rdata,
    output logic                    resp_err
);
    localparam int W    = 8 * DATA_BYTES;
    localparam int OFFW = $clog2(DATA_BYTES);
    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam longint unsigned MEM_BYTES = longint'(DEPTH_WORDS) * longint'(DATA_BYTES);

    typedef enum logic [1:0] {IDLE, RD, MRG, RESP} state_t;

    state_t          state_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [W-1:0]    resp_rdata_q;
    logic            resp_err_q;
    logic            wren_q;
    logic            we_q;
    logic            signed_q;
    logic [3:0]      n_q;
    logic [OFFW-1:0] off_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    wdata_q;

    logic [3:0]      req_n;
    logic            req_err;

    logic [W-1:0]    mem [DEPTH_WORDS];
    logic [W-1:0]    ram_q;

    logic [3:0]      lane_sh;
    logic [6:0]      bit_sh;
    logic [W-1:0]    field_mask;
    logic [W-1:0]    field;
    logic [W-1:0]    ext_data;
    logic [W-1:0]    merged;
    logic            sign_bit;

    // Oversize, misaligned and out-of-range requests never reach the RAM.
    assign req_n   = 4'd1 << req_size;
    assign req_err = (req_n > 4'(DATA_BYTES))
                  || ((req_addr[OFFW-1:0] & OFFW'(req_n - 4'd1)) != '0)
                  || (64'(req_addr) >= MEM_BYTES);

    // Both lane orders place the field in one contiguous bit range; only the shift differs.
    always_comb begin
`ifdef BYTE_LANE_MEMORY_BIG_ENDIAN_EN
        lane_sh = 4'(DATA_BYTES) - 4'(off_q) - n_q;
`else
        lane_sh = 4'(off_q);
`endif
        bit_sh     = {lane_sh, 3'b000};
        field_mask = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < int'(n_q)) field_mask[8*i +: 8] = 8'hFF;
        end
        field    = (ram_q >> bit_sh) & field_mask;
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i == int'(n_q) - 1) sign_bit = field[8*i+7];
        end
        ext_data = (signed_q && sign_bit) ? (field | ~field_mask) : field;
        merged   = (ram_q & ~(field_mask << bit_sh)) | ((wdata_q & field_mask) << bit_sh);
    end

    // RAM contents survive reset; wren_q is only ever high during MRG.
    always_ff @(posedge clk) begin
        if (wren_q) mem[idx_q] <= merged;
        if (state_q == RD) ram_q <= mem[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wren_q       <= 1'b0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            n_q          <= 4'd1;
            off_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wren_q <= 1'b0;
                    if (req_valid) begin
                        we_q        <= req_we;
                        signed_q    <= req_signed;
                        n_q         <= req_n;
                        off_q       <= req_addr[OFFW-1:0];
                        idx_q       <= req_addr[OFFW +: IDXW];
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    wren_q  <= we_q;
                    state_q <= MRG;
                end
                MRG: begin
                    wren_q       <= 1'b0;
                    resp_rdata_q <= we_q ? '0 : ext_data;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule
